line_memory: RTL

- Backing data memory for the cache; it is the responder end of the cache-to-memory line interface.
- Services whole-line reads and writes (4 x 32-bit words = 128 bits) with a fixed, parameterised access latency.
- Signals completion with busywait/done handshakes.
- Sits directly below the cache in the memory hierarchy and holds a small array of cache lines.

---
 rtl/line_memory.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/line_memory.sv
// line_memory: line-granular backing store below the cache.
// Each access (read or write of one 128-bit line) takes LATENCY busy cycles.
// Completion is a one-cycle done pulse. The FSM then parks in RELEASE until
// both request levels drop, so a held request cannot re-trigger.
// Optional: define LINE_MEM_ERR_EN to add a sticky err_o. It flags
// simultaneous read+write requests or a line address outside the array.
module line_memory #(
    parameter int WORD_W     = 32,
    parameter int BLOCK_LOG2 = 2,
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 4
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  m_read_i,
    input  logic                                  m_wr_i,
    input  logic [ADDR_W-BLOCK_LOG2-3:0]          m_address_i,
    input  logic [WORD_W*(2**BLOCK_LOG2)-1:0]     m_write_data_i,
    output logic [WORD_W*(2**BLOCK_LOG2)-1:0]     m_read_data_o,
    output logic                                  m_busywait_o,
    output logic                                  m_read_done_o,
    output logic                                  m_write_done_o
`ifdef LINE_MEM_ERR_EN
    ,
    output logic                                  err_o
`endif
);

    localparam int LINE_W = WORD_W * (2**BLOCK_LOG2);
    localparam int LA_W   = ADDR_W - BLOCK_LOG2 - 2;
    localparam int DEPTH  = 2**DEPTH_LOG2;
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, RELEASE} state_e;

    state_e                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    op_wr_q, op_wr_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [LINE_W-1:0]       wdata_q, wdata_d;
    logic [LINE_W-1:0]       rdata_q, rdata_d;
    logic                    accept;
    logic                    mem_we;
    logic [LINE_W-1:0]       mem_q [DEPTH];

    // Next-state, latching of the request, and access on the final busy edge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        accept  = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (m_wr_i || m_read_i) begin
                    accept  = 1'b1;
                    op_wr_d = m_wr_i;  // write wins when both are high
                    idx_d   = m_address_i[DEPTH_LOG2-1:0];
                    wdata_d = m_write_data_i;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = DONE;
                    if (op_wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem_q[idx_q];
                    end
                end
            end
            DONE: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!m_read_i && !m_wr_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and data registers; reset aborts any access in flight
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Line array, deliberately not reset; write enable is gated by the FSM
    // state, so an asynchronous reset also suppresses a pending commit
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign m_read_data_o  = rdata_q;
    assign m_busywait_o   = (state_q == BUSY);
    assign m_read_done_o  = (state_q == DONE) && !op_wr_q;
    assign m_write_done_o = (state_q == DONE) && op_wr_q;

`ifdef LINE_MEM_ERR_EN
    logic err_q, err_d;

    // Sticky error: conflicting requests or address beyond the array
    always_comb begin
        err_d = err_q;
        if (accept && ((m_read_i && m_wr_i) || (|m_address_i[LA_W-1:DEPTH_LOG2]))) begin
            err_d = 1'b1;
        end
    end

    // Error flag register, cleared only by reset
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    // Upper line-address bits alias onto the array and are otherwise unused
    logic unused_addr_hi;
    assign unused_addr_hi = ^m_address_i[LA_W-1:DEPTH_LOG2];
`endif

endmodule
